mc_controller: RTL and testbench

Multi-cycle successor to the single-cycle CPU controller: sequences each instruction through fetch, decode, execute, memory and write-back states instead of asserting all controls in one cycle. Adds a memory-ready handshake with wait states, a memory timeout watchdog, and an optional call-depth guard. It sits between the instruction register/flag registers and the datapath, driving the same control signal set plus fetch and handshake controls.

---
 rtl/mc_controller_pkg.sv | 45 ++++
 rtl/mc_controller_if.sv | 45 ++++
 rtl/mc_decode.sv | 45 ++++
 rtl/mc_controller.sv | 215 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multi-cycle controller: FSM states,
// opcode encodings, ALU-op constants and the decoder result record.
package mc_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_IMM,
        CLS_MEM,
        CLS_CTRL,
        CLS_NOP
    } op_class_e;

    localparam logic [4:0] OP_LD   = 5'b10000;
    localparam logic [4:0] OP_ST   = 5'b10001;
    localparam logic [4:0] OP_BZ   = 5'b10100;
    localparam logic [4:0] OP_BNZ  = 5'b10101;
    localparam logic [4:0] OP_BC   = 5'b10110;
    localparam logic [4:0] OP_BNC  = 5'b10111;
    localparam logic [4:0] OP_JMP  = 5'b11100;
    localparam logic [4:0] OP_CALL = 5'b11101;
    localparam logic [4:0] OP_RET  = 5'b11110;

    localparam logic [3:0] ALU_OP_PASS = 4'd0;
    localparam logic [3:0] ALU_OP_EXT  = 4'd8;

    typedef struct packed {
        op_class_e  cls;
        logic [3:0] alu_op;
        logic       imm_and_mem;
        logic       c_write_en;
        logic       z_write_en;
    } dec_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> IR/flags/datapath/memory signal bundle. The master side is the
// controller; the slave side is everything it steers.
interface mc_controller_if #(
    parameter int ALU_OP_W = 4
);
    logic                start;
    logic                halt;
    logic [4:0]          opcode_func;
    logic                c_in;
    logic                z_in;
    logic                mem_ready;

    logic                mem_req;
    logic                ir_load;
    logic                pc_en;
    logic                reg_write_en;
    logic                mem_write_en;
    logic                imm_and_mem;
    logic                ldm;
    logic                stm;
    logic                branch;
    logic                jmp;
    logic                ret;
    logic                push;
    logic                pop;
    logic                c_write_en;
    logic                z_write_en;
    logic [ALU_OP_W-1:0] alu_op;
    logic                busy;
    logic                fault;

    modport master (
        input  start, halt, opcode_func, c_in, z_in, mem_ready,
        output mem_req, ir_load, pc_en, reg_write_en, mem_write_en, imm_and_mem,
               ldm, stm, branch, jmp, ret, push, pop, c_write_en, z_write_en,
               alu_op, busy, fault
    );

    modport slave (
        output start, halt, opcode_func, c_in, z_in, mem_ready,
        input  mem_req, ir_load, pc_en, reg_write_en, mem_write_en, imm_and_mem,
               ldm, stm, branch, jmp, ret, push, pop, c_write_en, z_write_en,
               alu_op, busy, fault
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational opcode classifier: instruction class, base ALU op and flag
// write enables, shared by the DECODE and EXEC states.
module mc_decode
    import mc_controller_pkg::*;
(
    input  logic [4:0] opcode_func,
    output dec_t       dec
);

    always_comb begin
        // NOTE: every field gets a default before the case so no path can infer a latch.
        dec.cls         = CLS_NOP;
        dec.alu_op      = ALU_OP_PASS;
        dec.imm_and_mem = 1'b0;
        dec.c_write_en  = 1'b0;
        dec.z_write_en  = 1'b0;

        casez (opcode_func)
            5'b00???: begin
                dec.cls        = CLS_ALU;
                dec.alu_op     = {1'b0, opcode_func[2:0]};
                dec.c_write_en = 1'b1;
                dec.z_write_en = 1'b1;
            end
            5'b01???: begin
                dec.cls         = CLS_IMM;
                dec.alu_op      = {1'b0, opcode_func[2:0]};
                dec.imm_and_mem = 1'b1;
                dec.c_write_en  = 1'b1;
                dec.z_write_en  = 1'b1;
            end
            // 11000/11001 update both flags; 11010/11011 update Z only.
            5'b110??: begin
                dec.cls        = CLS_ALU;
                dec.alu_op     = ALU_OP_EXT | {2'b00, opcode_func[1:0]};
                dec.c_write_en = ~opcode_func[1];
                dec.z_write_en = 1'b1;
            end
            OP_LD, OP_ST: dec.cls = CLS_MEM;
            OP_BZ, OP_BNZ, OP_BC, OP_BNC, OP_JMP, OP_CALL, OP_RET: dec.cls = CLS_CTRL;
            default: dec.cls = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle CPU controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// mem_ready handshake and watchdog. Define CTRL_CALL_GUARD_EN to add the call-depth guard.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int ALU_OP_W    = 4,
    parameter int CALL_DEPTH  = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    mc_controller_if.master       bus
);

    localparam int WD_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [WD_W-1:0] wd_next;
    logic            wd_hit;
    dec_t            dec;
    logic [3:0]      alu_base;
    logic            call_fire, ret_fire;
    logic            call_block, ret_block;

    mc_decode u_decode (
        .opcode_func (bus.opcode_func),
        .dec         (dec)
    );

    assign wd_next = wd_cnt_q + WD_W'(1);
    assign wd_hit  = (MEM_TIMEOUT != 0) && (wd_next == WD_LIMIT);

    always_comb begin
        state_d          = state_q;
        wd_cnt_d         = '0;
        call_fire        = 1'b0;
        ret_fire         = 1'b0;
        alu_base         = ALU_OP_PASS;
        bus.mem_req      = 1'b0;
        bus.ir_load      = 1'b0;
        bus.pc_en        = 1'b0;
        bus.reg_write_en = 1'b0;
        bus.mem_write_en = 1'b0;
        bus.imm_and_mem  = 1'b0;
        bus.ldm          = 1'b0;
        bus.stm          = 1'b0;
        bus.branch       = 1'b0;
        bus.jmp          = 1'b0;
        bus.ret          = 1'b0;
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.c_write_en   = 1'b0;
        bus.z_write_en   = 1'b0;

        unique case (state_q)
            ST_IDLE:  if (bus.start)  state_d = ST_ARMED;
            ST_ARMED: if (!bus.start) state_d = ST_FETCH;

            ST_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_load = 1'b1;
                    state_d     = ST_DECODE;
                end else if (wd_hit) begin
                    state_d = ST_FAULT;
                end else begin
                    wd_cnt_d = wd_next;
                end
            end

            ST_DECODE: begin
                if (bus.halt) begin
                    state_d = ST_IDLE;
                end else begin
                    unique case (dec.cls)
                        CLS_ALU, CLS_IMM: state_d = ST_EXEC;
                        CLS_MEM:          state_d = ST_MEM;
                        CLS_CTRL: begin
                            state_d   = ST_FETCH;
                            bus.pc_en = 1'b1;
                            if (bus.opcode_func == OP_JMP) begin
                                bus.jmp = 1'b1;
                            end else if (bus.opcode_func == OP_CALL) begin
                                if (call_block) begin
                                    state_d   = ST_FAULT;
                                    bus.pc_en = 1'b0;
                                end else begin
                                    bus.jmp   = 1'b1;
                                    bus.push  = 1'b1;
                                    call_fire = 1'b1;
                                end
                            end else if (bus.opcode_func == OP_RET) begin
                                if (ret_block) begin
                                    state_d   = ST_FAULT;
                                    bus.pc_en = 1'b0;
                                end else begin
                                    bus.ret  = 1'b1;
                                    bus.pop  = 1'b1;
                                    ret_fire = 1'b1;
                                end
                            end else begin
                                // Bits [1:0] of 101xx select z, !z, c, !c.
                                unique case (bus.opcode_func[1:0])
                                    2'b00: bus.branch = bus.z_in;
                                    2'b01: bus.branch = ~bus.z_in;
                                    2'b10: bus.branch = bus.c_in;
                                    2'b11: bus.branch = ~bus.c_in;
                                endcase
                            end
                        end
                        default: begin
                            bus.pc_en = 1'b1;
                            state_d   = ST_FETCH;
                        end
                    endcase
                end
            end

            ST_EXEC: begin
                alu_base         = dec.alu_op;
                bus.reg_write_en = 1'b1;
                bus.pc_en        = 1'b1;
                bus.imm_and_mem  = dec.imm_and_mem;
                bus.c_write_en   = dec.c_write_en;
                bus.z_write_en   = dec.z_write_en;
                state_d          = ST_FETCH;
            end

            ST_MEM: begin
                bus.mem_req      = 1'b1;
                bus.imm_and_mem  = 1'b1;
                bus.ldm          = (bus.opcode_func != OP_ST);
                bus.stm          = (bus.opcode_func == OP_ST);
                bus.mem_write_en = (bus.opcode_func == OP_ST);
                if (bus.mem_ready) begin
                    if (bus.opcode_func == OP_ST) begin
                        bus.pc_en = 1'b1;
                        state_d   = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wd_hit) begin
                    state_d = ST_FAULT;
                end else begin
                    wd_cnt_d = wd_next;
                end
            end

            ST_WB: begin
                bus.reg_write_en = 1'b1;
                bus.ldm          = 1'b1;
                bus.imm_and_mem  = 1'b1;
                bus.pc_en        = 1'b1;
                state_d          = ST_FETCH;
            end

            ST_FAULT: state_d = ST_FAULT;

            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.alu_op = ALU_OP_W'(alu_base);
    assign bus.busy   = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                        (state_q == ST_EXEC)  || (state_q == ST_MEM)    ||
                        (state_q == ST_WB);
    assign bus.fault  = (state_q == ST_FAULT);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

`ifdef CTRL_CALL_GUARD_EN
    localparam int DEPTH_W = $clog2(CALL_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(CALL_DEPTH);

    logic [DEPTH_W-1:0] depth_q, depth_d;

    assign call_block = (depth_q == DEPTH_MAX);
    assign ret_block  = (depth_q == '0);

    always_comb begin
        depth_d = depth_q;
        if (call_fire) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (ret_fire) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end
`else
    // Without the guard, calls and returns are never blocked and depth is not tracked.
    logic unused_guard;
    assign call_block   = 1'b0;
    assign ret_block    = 1'b0;
    assign unused_guard = call_fire ^ ret_fire ^ (CALL_DEPTH > 0);
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller with hand-computed control
// vectors; guard expectations follow CTRL_CALL_GUARD_EN.
module tb_mc_controller;
    import mc_controller_pkg::*;

    localparam logic [16:0] M_MEMREQ = 17'd1 << 16;
    localparam logic [16:0] M_IRLOAD = 17'd1 << 15;
    localparam logic [16:0] M_PCEN   = 17'd1 << 14;
    localparam logic [16:0] M_REGW   = 17'd1 << 13;
    localparam logic [16:0] M_MEMW   = 17'd1 << 12;
    localparam logic [16:0] M_IMM    = 17'd1 << 11;
    localparam logic [16:0] M_LDM    = 17'd1 << 10;
    localparam logic [16:0] M_STM    = 17'd1 << 9;
    localparam logic [16:0] M_BRANCH = 17'd1 << 8;
    localparam logic [16:0] M_JMP    = 17'd1 << 7;
    localparam logic [16:0] M_RET    = 17'd1 << 6;
    localparam logic [16:0] M_PUSH   = 17'd1 << 5;
    localparam logic [16:0] M_POP    = 17'd1 << 4;
    localparam logic [16:0] M_CWE    = 17'd1 << 3;
    localparam logic [16:0] M_ZWE    = 17'd1 << 2;
    localparam logic [16:0] M_BUSY   = 17'd1 << 1;
    localparam logic [16:0] M_FAULT  = 17'd1;

    localparam logic [16:0] FETCH_OK = M_MEMREQ | M_IRLOAD | M_BUSY;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mc_controller_if #(.ALU_OP_W(4)) bus ();

    mc_controller #(
        .ALU_OP_W    (4),
        .CALL_DEPTH  (2),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [16:0] ctl;
    assign ctl = {bus.mem_req, bus.ir_load, bus.pc_en, bus.reg_write_en, bus.mem_write_en,
                  bus.imm_and_mem, bus.ldm, bus.stm, bus.branch, bus.jmp, bus.ret,
                  bus.push, bus.pop, bus.c_write_en, bus.z_write_en, bus.busy, bus.fault};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step_check(input string tag, input logic [16:0] exp);
        @(negedge clk);
        #1;
        check(tag, 32'(ctl), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ctl", 32'(ctl), 32'd0);
    endtask

    task automatic arm();
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        check("arm_idle", 32'(ctl), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check("arm_armed", 32'(ctl), 32'd0);
    endtask

    task automatic fetch(input logic [4:0] op);
        @(negedge clk);
        bus.opcode_func = op;
        bus.mem_ready   = 1'b1;
        #1;
        check("fetch", 32'(ctl), 32'(FETCH_OK));
    endtask

    task automatic exec_op(input string tag, input logic [4:0] op,
                           input logic [16:0] exp, input logic [3:0] exp_alu);
        fetch(op);
        step_check({tag, "_dec"}, M_BUSY);
        step_check({tag, "_exec"}, exp);
        check({tag, "_alu"}, 32'(bus.alu_op), 32'(exp_alu));
    endtask

    task automatic branch_op(input string tag, input logic [4:0] op,
                             input logic c, input logic z, input logic [16:0] exp);
        bus.c_in = c;
        bus.z_in = z;
        fetch(op);
        step_check(tag, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.halt        = 1'b0;
        bus.opcode_func = 5'b00000;
        bus.c_in        = 1'b0;
        bus.z_in        = 1'b0;
        bus.mem_ready   = 1'b0;

        do_reset();
        check("reset_alu", 32'(bus.alu_op), 32'd0);
        arm();

        exec_op("alu3",  5'b00011, M_REGW | M_PCEN | M_CWE | M_ZWE | M_BUSY, 4'd3);
        exec_op("imm2",  5'b01010, M_REGW | M_PCEN | M_CWE | M_ZWE | M_IMM | M_BUSY, 4'd2);
        exec_op("alu9",  5'b11001, M_REGW | M_PCEN | M_CWE | M_ZWE | M_BUSY, 4'd9);
        exec_op("alu10", 5'b11010, M_REGW | M_PCEN | M_ZWE | M_BUSY, 4'd10);

        // Load with two wait states: MEM lasts three cycles, six in total.
        fetch(OP_LD);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("ld_dec", 32'(ctl), 32'(M_BUSY));
        for (int i = 0; i < 2; i++) begin
            step_check("ld_wait", M_MEMREQ | M_IMM | M_LDM | M_BUSY);
            check("ld_wait_alu", 32'(bus.alu_op), 32'd0);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        check("ld_ack", 32'(ctl), 32'(M_MEMREQ | M_IMM | M_LDM | M_BUSY));
        step_check("ld_wb", M_REGW | M_LDM | M_IMM | M_PCEN | M_BUSY);

        fetch(OP_ST);
        step_check("st_dec", M_BUSY);
        step_check("st_mem", M_MEMREQ | M_IMM | M_STM | M_MEMW | M_PCEN | M_BUSY);

        branch_op("bnz_z0", OP_BNZ, 1'b0, 1'b0, M_BRANCH | M_PCEN | M_BUSY);
        branch_op("bnz_z1", OP_BNZ, 1'b0, 1'b1, M_PCEN | M_BUSY);
        branch_op("bz_z1",  OP_BZ,  1'b0, 1'b1, M_BRANCH | M_PCEN | M_BUSY);
        branch_op("bc_c1",  OP_BC,  1'b1, 1'b0, M_BRANCH | M_PCEN | M_BUSY);
        branch_op("bnc_c1", OP_BNC, 1'b1, 1'b0, M_PCEN | M_BUSY);
        branch_op("jmp",    OP_JMP, 1'b0, 1'b0, M_JMP | M_PCEN | M_BUSY);
        branch_op("nop",    5'b10010, 1'b0, 1'b0, M_PCEN | M_BUSY);

        // Halt beats a jump in the same DECODE cycle.
        fetch(OP_JMP);
        @(negedge clk);
        bus.halt = 1'b1;
        #1;
        check("halt_dec", 32'(ctl), 32'(M_BUSY));
        @(negedge clk);
        bus.halt = 1'b0;
        #1;
        check("halt_idle", 32'(ctl), 32'd0);

        // Reset in the middle of a stalled store.
        arm();
        fetch(OP_ST);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        check("rst_st_dec", 32'(ctl), 32'(M_BUSY));
        step_check("rst_st_wait", M_MEMREQ | M_IMM | M_STM | M_MEMW | M_BUSY);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid", 32'(ctl), 32'd0);

        // Watchdog: four waiting FETCH cycles, then FAULT until reset.
        arm();
        @(negedge clk);
        bus.opcode_func = 5'b00000;
        bus.mem_ready   = 1'b0;
        #1;
        check("wd_wait", 32'(ctl), 32'(M_MEMREQ | M_BUSY));
        for (int i = 0; i < 3; i++) step_check("wd_wait", M_MEMREQ | M_BUSY);
        step_check("wd_fault", M_FAULT);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        check("wd_stuck", 32'(ctl), 32'(M_FAULT));
        bus.start = 1'b0;
        step_check("wd_stuck2", M_FAULT);
        do_reset();
        check("wd_rst_alu", 32'(bus.alu_op), 32'd0);

        // Calls: guard with depth 2 faults on the third.
        arm();
        branch_op("call1", OP_CALL, 1'b0, 1'b0, M_JMP | M_PUSH | M_PCEN | M_BUSY);
        branch_op("call2", OP_CALL, 1'b0, 1'b0, M_JMP | M_PUSH | M_PCEN | M_BUSY);
`ifdef CTRL_CALL_GUARD_EN
        branch_op("call3", OP_CALL, 1'b0, 1'b0, M_BUSY);
        step_check("call3_fault", M_FAULT);
`else
        branch_op("call3", OP_CALL, 1'b0, 1'b0, M_JMP | M_PUSH | M_PCEN | M_BUSY);
        fetch(5'b00000);
`endif
        do_reset();
        arm();
`ifdef CTRL_CALL_GUARD_EN
        branch_op("ret0", OP_RET, 1'b0, 1'b0, M_BUSY);
        step_check("ret0_fault", M_FAULT);
`else
        branch_op("ret0", OP_RET, 1'b0, 1'b0, M_RET | M_POP | M_PCEN | M_BUSY);
        step_check("ret0_next", FETCH_OK);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
